btn_event_encoder: RTL and testbench

- Player-input front end for the Genius game.
- Synchronises and debounces the 3 raw push-buttons, then detects press edges.
- Encodes each press into the same 2-bit symbol code the sequence generator emits, and delivers events through a valid/ready handshake with a 2-entry queue.
- The game FSM consumes one event per player choice instead of sampling raw buttons.

---
 rtl/genius_pkg.sv | 45 ++++
 rtl/btn_event_encoder_if.sv | 31 +++
 rtl/btn_debounce.sv | 105 ++++++++++
 rtl/btn_event_encoder.sv | 149 ++++++++++++++
 tb/tb_btn_event_encoder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/genius_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : genius_pkg
//  Description : Shared symbol encoding for the Genius game. The sequence
//                generator, the choice verifier and the button event encoder
//                all speak this 2-bit code.
//  Macros      : BTN_RELEASE_EVT_EN - adds a release flag to each queue entry
//  Revision    : 1.0 - initial release
// ============================================================================
package genius_pkg;

    localparam int NUM_BTNS = 3;
    localparam int CODE_W   = 2;

    localparam logic [CODE_W-1:0] CODE_BTN0  = 2'd0;
    localparam logic [CODE_W-1:0] CODE_BTN1  = 2'd1;
    localparam logic [CODE_W-1:0] CODE_BTN2  = 2'd2;
    localparam logic [CODE_W-1:0] CODE_MULTI = 2'd3;

    // The event queue is architecturally two entries deep.
    localparam logic [1:0] QUEUE_DEPTH = 2'd2;

    typedef struct packed {
`ifdef BTN_RELEASE_EVT_EN
        logic              rel;
`endif
        logic [CODE_W-1:0] code;
    } ev_entry_t;

    // Map a one-hot button vector to its symbol; anything with more than one
    // bit set collapses to CODE_MULTI. Callers only invoke this with at least
    // one bit set.
    function automatic logic [CODE_W-1:0] encode_btns(input logic [NUM_BTNS-1:0] v);
        logic [CODE_W-1:0] r;
        case (v)
            3'b001:  r = CODE_BTN0;
            3'b010:  r = CODE_BTN1;
            3'b100:  r = CODE_BTN2;
            default: r = CODE_MULTI;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_event_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_encoder_if
//  Description : Valid/ready event channel from the button encoder to the
//                game FSM.
//  Signals     : ev_valid   - head event present
//                ev_ready   - consumer takes the head event this cycle
//                ev_code    - head event symbol (genius_pkg codes)
//                ev_release - head event is a release (BTN_RELEASE_EVT_EN only)
//  Modports    : master (event producer), slave (event consumer)
//  Macros      : BTN_RELEASE_EVT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
interface btn_event_encoder_if;
    import genius_pkg::*;

    logic              ev_valid;
    logic              ev_ready;
    logic [CODE_W-1:0] ev_code;
`ifdef BTN_RELEASE_EVT_EN
    logic              ev_release;

    modport master (output ev_valid, output ev_code, output ev_release, input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_release, output ev_ready);
`else
    modport master (output ev_valid, output ev_code, input ev_ready);
    modport slave  (input ev_valid, input ev_code, output ev_ready);
`endif

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : One push-button front end: polarity fix, 2-flop
//                synchroniser, persistence debounce counter, debounced level
//                and single-cycle press (and optionally release) pulses.
//  Ports       : clock      - system clock
//                reset      - synchronous, active-low reset
//                i_btn_raw  - raw asynchronous button level
//                o_stable   - debounced level, 1 = pressed
//                o_rise     - one-cycle pulse on a debounced press
//                o_fall     - one-cycle pulse on a debounced release
//                             (BTN_RELEASE_EVT_EN only)
//  Macros      : BTN_RELEASE_EVT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_btn_raw,
    output logic      o_stable,
    output logic      o_rise
`ifdef BTN_RELEASE_EVT_EN
    ,
    output logic      o_fall
`endif
);

    localparam logic [15:0] c_CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        w_pressed;
    logic        w_toggle;
    logic        r_sync1;
    logic        r_sync2;
    logic [1:0]  r_prime;
    logic [15:0] r_cnt;
    logic        r_stable;
    logic        r_armed;
    logic        r_rise;

    assign w_pressed = BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;

    // The new level has persisted for DEBOUNCE_CYCLES consecutive samples.
    assign w_toggle  = (r_sync2 != r_stable) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prime  <= 2'b00;
            r_cnt    <= 16'd0;
            r_stable <= 1'b0;
            r_armed  <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_sync1 <= w_pressed;
            r_sync2 <= r_sync1;
            // r_prime[1] marks that r_sync2 now carries a real sample rather
            // than its reset value.
            r_prime <= {r_prime[0], 1'b1};

            if (r_sync2 == r_stable || w_toggle) begin
                r_cnt <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_toggle) begin
                r_stable <= ~r_stable;
            end

            // A button held through reset must be seen released before any
            // of its edges are reported. Arm once the debounced level is low
            // with a genuinely low input, or on a debounced release.
            if ((r_prime[1] && !r_sync2 && !r_stable) || (w_toggle && r_stable)) begin
                r_armed <= 1'b1;
            end

            // Pulses are raised on the same edge that updates r_stable.
            r_rise <= w_toggle && !r_stable && r_armed;
        end
    end

`ifdef BTN_RELEASE_EVT_EN
    logic r_fall;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fall <= 1'b0;
        end else begin
            r_fall <= w_toggle && r_stable && r_armed;
        end
    end

    assign o_fall = r_fall;
`endif

    assign o_stable = r_stable;
    assign o_rise   = r_rise;

endmodule
`default_nettype wire

// File: rtl/btn_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_encoder
//  Description : Player-input front end for the Genius game. Debounces three
//                push-buttons, encodes each press into the shared symbol code
//                and delivers it through a 2-entry valid/ready event queue.
//  Ports       : clock        - system clock
//                reset        - synchronous, active-low reset
//                i_btn        - raw asynchronous button levels
//                ev_if        - event channel (master): ev_valid, ev_code,
//                               ev_ready, ev_release (macro only)
//                o_btn_stable - debounced pressed level per button
//                o_overflow   - sticky: an event was dropped on a full queue
//  Macros      : BTN_RELEASE_EVT_EN - also queue debounced releases, flagged
//                                     by ev_release
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_event_encoder
    import genius_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  wire logic                clock,
    input  wire logic                reset,
    input  wire logic [NUM_BTNS-1:0] i_btn,
    btn_event_encoder_if.master      ev_if,
    output logic [NUM_BTNS-1:0]      o_btn_stable,
    output logic                     o_overflow
);

    logic [NUM_BTNS-1:0] w_stable;
    logic [NUM_BTNS-1:0] w_rise;
`ifdef BTN_RELEASE_EVT_EN
    logic [NUM_BTNS-1:0] w_fall;
`endif

    // ------------------------------------------------------------------
    // Per-button synchronise / debounce / edge detect
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_debounce (
            .clock     (clock),
            .reset     (reset),
            .i_btn_raw (i_btn[g]),
            .o_stable  (w_stable[g]),
            .o_rise    (w_rise[g])
`ifdef BTN_RELEASE_EVT_EN
            ,
            .o_fall    (w_fall[g])
`endif
        );
    end

    // ------------------------------------------------------------------
    // Encoder: presses win over releases; a dropped release is not an
    // overflow because it never competed for a queue slot.
    // ------------------------------------------------------------------
    logic      w_push_req;
    ev_entry_t w_push_entry;

    always_comb begin
        w_push_req   = 1'b0;
        w_push_entry = '0;
        if (|w_rise) begin
            w_push_req        = 1'b1;
            w_push_entry.code = encode_btns(w_rise);
        end
`ifdef BTN_RELEASE_EVT_EN
        else if (|w_fall) begin
            w_push_req        = 1'b1;
            w_push_entry.code = encode_btns(w_fall);
            w_push_entry.rel  = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Two-entry queue as a shift structure: r_q0 is always the head, so
    // the outputs come straight from a flop and simply hold their last
    // value once the queue drains.
    // ------------------------------------------------------------------
    ev_entry_t  r_q0;
    ev_entry_t  r_q1;
    logic [1:0] r_count;
    logic       r_overflow;
    logic       w_pop;
    logic       w_full;

    assign w_pop  = (r_count != 2'd0) && ev_if.ev_ready;
    assign w_full = (r_count == QUEUE_DEPTH);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_q0       <= '0;
            r_q1       <= '0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end

            case (r_count)
                2'd0: begin
                    if (w_push_req) begin
                        r_q0    <= w_push_entry;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_pop && w_push_req) begin
                        r_q0 <= w_push_entry;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end else if (w_push_req) begin
                        r_q1    <= w_push_entry;
                        r_count <= 2'd2;
                    end
                end
                default: begin
                    // Full: a push only lands when the head leaves.
                    if (w_pop) begin
                        r_q0 <= r_q1;
                        if (w_push_req) begin
                            r_q1 <= w_push_entry;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign ev_if.ev_valid = (r_count != 2'd0);
    assign ev_if.ev_code  = r_q0.code;
`ifdef BTN_RELEASE_EVT_EN
    assign ev_if.ev_release = r_q0.rel;
`endif

    assign o_btn_stable = w_stable;
    assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_event_encoder
//  Description : Self-checking bench for btn_event_encoder (DEBOUNCE_CYCLES=4,
//                active-low buttons). Directed scenarios plus a randomized
//                run against a history-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_encoder;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] btn   = 3'b111;
    logic [2:0] btn_stable;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    btn_event_encoder_if ev_if ();

    btn_event_encoder #(
        .DEBOUNCE_CYCLES (D),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_btn        (btn),
        .ev_if        (ev_if),
        .o_btn_stable (btn_stable),
        .o_overflow   (overflow)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Reference model. Works from the history of sampled button levels:
    // the debouncer sees each sample two edges late and accepts a new level
    // once the last D seen samples all disagree with the accepted one.
    // ------------------------------------------------------------------
    logic [2:0] m_raw_q[$];
    logic [2:0] m_syn_q[$];
    logic [1:0] m_q[$];
    logic [2:0] m_stable = 3'b000;
    logic [2:0] m_armed  = 3'b000;
    logic [2:0] m_press  = 3'b000;
    logic [1:0] m_code   = 2'd0;
    logic       m_ovf    = 1'b0;

    always @(posedge clock) begin
        logic [2:0] synced;
        logic [2:0] tgl;
        logic [2:0] press_now;
        logic       primed;
        logic       all_diff;
        int         nb;
        if (!reset) begin
            m_raw_q.delete();
            m_syn_q.delete();
            m_q.delete();
            m_stable = 3'b000;
            m_armed  = 3'b000;
            m_press  = 3'b000;
            m_code   = 2'd0;
            m_ovf    = 1'b0;
        end else begin
            primed = (m_raw_q.size() >= 2);
            synced = primed ? m_raw_q[m_raw_q.size()-2] : 3'b000;
            m_raw_q.push_back(~btn);
            if (m_raw_q.size() > 3) void'(m_raw_q.pop_front());
            m_syn_q.push_back(synced);
            if (m_syn_q.size() > D) void'(m_syn_q.pop_front());

            // queue: the press detected last edge is delivered now
            if (ev_if.ev_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (m_press != 3'b000) begin
                nb = 0;
                for (int i = 0; i < 3; i++) nb += int'(m_press[i]);
                if (m_q.size() < 2) begin
                    if (nb > 1) m_q.push_back(2'd3);
                    else if (m_press[0]) m_q.push_back(2'd0);
                    else if (m_press[1]) m_q.push_back(2'd1);
                    else m_q.push_back(2'd2);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_q.size() > 0) m_code = m_q[0];

            // debounce decisions
            tgl = 3'b000;
            for (int i = 0; i < 3; i++) begin
                all_diff = (m_syn_q.size() == D);
                for (int j = 0; j < m_syn_q.size(); j++)
                    if (m_syn_q[j][i] == m_stable[i]) all_diff = 1'b0;
                tgl[i] = all_diff;
            end
            press_now = tgl & ~m_stable & m_armed;
            for (int i = 0; i < 3; i++)
                if ((primed && !synced[i] && !m_stable[i]) || (tgl[i] && m_stable[i]))
                    m_armed[i] = 1'b1;
            m_stable = m_stable ^ tgl;
            m_press  = press_now;
        end
    end

    // ------------------------------------------------------------------
    task automatic do_reset();
        reset = 1'b0;
        ev_if.ev_ready = 1'b0;
        btn = 3'b111;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        btn = 3'b111;
        ev_if.ev_ready = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ev_if.ev_valid); end
        checks++; if (btn_stable !== 3'b000) begin errors++; $display("FAIL reset_stable got %b exp 000", btn_stable); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (ev_if.ev_code !== 2'd0) begin errors++; $display("FAIL reset_code got %0d exp 0", ev_if.ev_code); end
        reset = 1'b1;
        repeat (6) @(negedge clock);
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", ev_if.ev_valid); end
    endtask

    task automatic test_latency();
        ev_if.ev_ready = 1'b1;
        btn = 3'b101;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (k == 6) begin
                checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %b exp 0", ev_if.ev_valid); end
                checks++; if (btn_stable !== 3'b010) begin errors++; $display("FAIL latency_stable got %b exp 010", btn_stable); end
            end
            if (k == 7) begin
                checks++; if (ev_if.ev_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b exp 1", ev_if.ev_valid); end
                checks++; if (ev_if.ev_code !== 2'd1) begin errors++; $display("FAIL latency_code got %0d exp 1", ev_if.ev_code); end
            end
        end
        @(negedge clock);
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL latency_one_cycle got %b exp 0", ev_if.ev_valid); end
        btn = 3'b111;
        repeat (10) @(negedge clock);
        checks++; if (btn_stable !== 3'b000) begin errors++; $display("FAIL release_stable got %b exp 000", btn_stable); end
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL release_silent got %b exp 0", ev_if.ev_valid); end
    endtask

    task automatic test_glitch();
        int n;
        logic [1:0] c;
        n = 0;
        c = 2'd3;
        ev_if.ev_ready = 1'b1;
        btn = 3'b110;
        repeat (3) @(negedge clock);
        btn = 3'b111;
        @(negedge clock);
        btn = 3'b110;
        repeat (14) begin
            @(negedge clock);
            if (ev_if.ev_valid) begin n++; c = ev_if.ev_code; end
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL glitch_events got %0d exp 1", n); end
        checks++; if (c !== 2'd0) begin errors++; $display("FAIL glitch_code got %0d exp 0", c); end
        checks++; if (btn_stable !== 3'b001) begin errors++; $display("FAIL glitch_stable got %b exp 001", btn_stable); end
        btn = 3'b111;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_multi();
        int n;
        logic [1:0] c;
        n = 0;
        c = 2'd0;
        ev_if.ev_ready = 1'b1;
        btn = 3'b000;
        repeat (12) begin
            @(negedge clock);
            if (ev_if.ev_valid) begin n++; c = ev_if.ev_code; end
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL multi_events got %0d exp 1", n); end
        checks++; if (c !== 2'd3) begin errors++; $display("FAIL multi_code got %0d exp 3", c); end
        checks++; if (btn_stable !== 3'b111) begin errors++; $display("FAIL multi_stable got %b exp 111", btn_stable); end
        btn = 3'b111;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_overflow();
        ev_if.ev_ready = 1'b0;
        btn = 3'b110; repeat (8) @(negedge clock);
        btn = 3'b111; repeat (8) @(negedge clock);
        btn = 3'b101; repeat (8) @(negedge clock);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_two_entries got %b exp 0", overflow); end
        btn = 3'b111; repeat (8) @(negedge clock);
        btn = 3'b011; repeat (8) @(negedge clock);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (ev_if.ev_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b exp 1", ev_if.ev_valid); end
        checks++; if (ev_if.ev_code !== 2'd0) begin errors++; $display("FAIL ovf_head got %0d exp 0", ev_if.ev_code); end
        btn = 3'b111; repeat (8) @(negedge clock);
        ev_if.ev_ready = 1'b1;
        @(negedge clock);
        checks++; if (ev_if.ev_valid !== 1'b1) begin errors++; $display("FAIL ovf_pop1_valid got %b exp 1", ev_if.ev_valid); end
        checks++; if (ev_if.ev_code !== 2'd1) begin errors++; $display("FAIL ovf_pop1_code got %0d exp 1", ev_if.ev_code); end
        @(negedge clock);
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", ev_if.ev_valid); end
        repeat (3) @(negedge clock);
        checks++; if (ev_if.ev_code !== 2'd1) begin errors++; $display("FAIL code_hold got %0d exp 1", ev_if.ev_code); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        btn = 3'b011; repeat (8) @(negedge clock);
        btn = 3'b111; repeat (8) @(negedge clock);
        btn = 3'b101;
        repeat (6) @(negedge clock);
        checks++; if (ev_if.ev_code !== 2'd2 || ev_if.ev_valid !== 1'b1) begin errors++; $display("FAIL b2b_head got %b/%0d exp 1/2", ev_if.ev_valid, ev_if.ev_code); end
        ev_if.ev_ready = 1'b1;
        @(negedge clock);
        checks++; if (ev_if.ev_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", ev_if.ev_valid); end
        checks++; if (ev_if.ev_code !== 2'd1) begin errors++; $display("FAIL b2b_code got %0d exp 1", ev_if.ev_code); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b exp 0", overflow); end
        @(negedge clock);
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", ev_if.ev_valid); end
        btn = 3'b111; repeat (10) @(negedge clock);
    endtask

    task automatic test_reset_mid_debounce();
        int n;
        logic [1:0] c;
        ev_if.ev_ready = 1'b0;
        btn = 3'b110; repeat (8) @(negedge clock);
        btn = 3'b111; repeat (8) @(negedge clock);
        btn = 3'b011; repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", ev_if.ev_valid); end
        checks++; if (btn_stable !== 3'b000) begin errors++; $display("FAIL midrst_stable got %b exp 000", btn_stable); end
        reset = 1'b1;
        ev_if.ev_ready = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clock);
            if (ev_if.ev_valid) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL midrst_held_events got %0d exp 0", n); end
        checks++; if (btn_stable !== 3'b100) begin errors++; $display("FAIL midrst_held_stable got %b exp 100", btn_stable); end
        btn = 3'b111; repeat (10) @(negedge clock);
        btn = 3'b011;
        n = 0;
        c = 2'd0;
        repeat (10) begin
            @(negedge clock);
            if (ev_if.ev_valid) begin n++; c = ev_if.ev_code; end
        end
        checks++; if (n !== 1 || c !== 2'd2) begin errors++; $display("FAIL repress_event got n=%0d code=%0d exp n=1 code=2", n, c); end
        btn = 3'b111; repeat (10) @(negedge clock);
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        do_reset();
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clock);
            checks++; if (ev_if.ev_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, ev_if.ev_valid, (m_q.size() > 0)); end
            checks++; if (ev_if.ev_code !== m_code) begin errors++; $display("FAIL rnd_code cyc %0d got %0d exp %0d", cyc, ev_if.ev_code, m_code); end
            checks++; if (btn_stable !== m_stable) begin errors++; $display("FAIL rnd_stable cyc %0d got %b exp %b", cyc, btn_stable, m_stable); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow cyc %0d got %b exp %b", cyc, overflow, m_ovf); end
            if (hold == 0) begin
                btn  = 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            ev_if.ev_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 299) != 0);
        end
        reset = 1'b1;
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_multi();
        test_overflow();
        test_back_to_back();
        test_reset_mid_debounce();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached without completing tests");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
